matrix_loader: RTL and testbench



---
 rtl/ee354_fp_pkg.sv | 26 ++
 rtl/ee354_wait_timer.sv | 37 +++
 rtl/matrix_loader.sv | 185 ++++++++++++++++++
 tb/tb_matrix_loader.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ee354_fp_pkg.sv
// Shared definitions for the matrix loader and the determinant core:
// default matrix geometry, one-hot state encodings and the packed-matrix type.
package ee354_fp_pkg;

  localparam int MAT_N      = 8;   // matrix dimension
  localparam int MAT_W      = 32;  // element / determinant width
  localparam int FILL_CNT_W = 7;   // element counter width, holds 0..64

  // One-hot loader states; bit k of the encoding drives the matching q_ flag.
  typedef enum logic [4:0] {
    ST_FILL   = 5'b00001,
    ST_LAUNCH = 5'b00010,
    ST_WAIT   = 5'b00100,
    ST_RESULT = 5'b01000,
    ST_ERROR  = 5'b10000
  } state_t;

  // Packed matrix at the default geometry; element [r][c] at ((r*N+c)*W) +: W.
  typedef logic [MAT_N*MAT_N*MAT_W-1:0] matrix_t;

  // True when idx addresses the last element of an n x n matrix.
  function automatic logic is_final_index(input logic [FILL_CNT_W-1:0] idx, input int n);
    return (idx == FILL_CNT_W'(n * n - 1));
  endfunction

endpackage

// File: rtl/ee354_wait_timer.sv
// Watchdog for the WAIT state: counts enabled cycles and flags the cycle on
// which the count reaches the limit.
module ee354_wait_timer #(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic [CW-1:0] limit,
  output logic          expired
);

  logic [CW-1:0] r_count;
  logic [CW:0]   w_count_inc;

  // Count cycles while enabled; cleared by reset or whenever the caller is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  // Expiry fires on the enabled cycle whose increment would reach the limit;
  // the extra bit keeps the comparison safe at the top of the range.
  always_comb begin
    w_count_inc = {1'b0, r_count} + {{CW{1'b0}}, 1'b1};
    expired     = en && (w_count_inc >= {1'b0, limit});
  end

endmodule

// File: rtl/matrix_loader.sv
// Matrix loader: collects N*N row-major elements, launches the determinant
// core, waits (with watchdog) for its result and hands the result downstream.
module matrix_loader
  import ee354_fp_pkg::*;
#(
  parameter int N          = MAT_N,
  parameter int W          = MAT_W,
  parameter int WAIT_LIMIT = 65535
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             In_valid,
  input  logic [W-1:0]     In_data,
  input  logic             In_last,
  output logic             In_ready,
  output logic [N*N*W-1:0] Matrix,
  output logic             Start,
  input  logic             Done,
  input  logic [W-1:0]     Det_in,
  output logic             Ack,
  output logic [W-1:0]     Det_out,
  output logic             Det_valid,
  input  logic             Res_ready,
  output logic             Err,
  output logic [6:0]       Fill_count,
  output logic             q_Fill,
  output logic             q_Launch,
  output logic             q_Wait,
  output logic             q_Result,
  output logic             q_Error
);

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_clr_fill;
  logic               w_capture;
  logic               w_expired;
  logic               w_is_final;
  logic               w_in_wait;
  logic [6:0]         r_fill_count;
  logic [N*N*W-1:0]   r_matrix;
  logic [W-1:0]       r_det;

  assign w_is_final = is_final_index(r_fill_count, N);
  assign w_in_wait  = (r_state == ST_WAIT);

  ee354_wait_timer #(
    .CW (32)
  ) u_wait_timer (
    .clk     (Clk),
    .rst     (Reset),
    .en      (w_in_wait),
    .clr     (!w_in_wait),
    .limit   (32'(WAIT_LIMIT)),
    .expired (w_expired)
  );

  // State register; reset always returns to FILL.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and datapath strobes. Clear is only looked at in FILL and
  // ERROR so a started core handshake always runs to completion.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_clr_fill = 1'b0;
    w_capture  = 1'b0;
    case (r_state)
      ST_FILL: begin
        if (Clear) begin
          w_clr_fill = 1'b1;
          w_next     = ST_FILL;
        end else if (In_valid) begin
          w_accept = 1'b1;
          if (In_last && w_is_final) begin
            w_next = ST_LAUNCH;
          end else if (In_last || w_is_final) begin
            w_next = ST_ERROR;
          end else begin
            w_next = ST_FILL;
          end
        end else begin
          w_next = ST_FILL;
        end
      end
      ST_LAUNCH: begin
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (Done) begin
          w_capture = 1'b1;
          w_next    = ST_RESULT;
        end else if (w_expired) begin
          w_next = ST_ERROR;
        end else begin
          w_next = ST_WAIT;
        end
      end
      ST_RESULT: begin
        if (Res_ready) begin
          w_clr_fill = 1'b1;
          w_next     = ST_FILL;
        end else begin
          w_next = ST_RESULT;
        end
      end
      ST_ERROR: begin
        if (Clear) begin
          w_clr_fill = 1'b1;
          w_next     = ST_FILL;
        end else begin
          w_next = ST_ERROR;
        end
      end
      default: begin
        w_clr_fill = 1'b1;
        w_next     = ST_FILL;
      end
    endcase
  end

  // Element counter: advances per accepted element, cleared on restart.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fill_count <= 7'd0;
    end else if (w_clr_fill) begin
      r_fill_count <= 7'd0;
    end else if (w_accept) begin
      r_fill_count <= r_fill_count + 7'd1;
    end else begin
      r_fill_count <= r_fill_count;
    end
  end

  // Matrix storage: only accepted FILL writes change it, so it is stable
  // for the whole core handshake and survives Clear.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_matrix <= '0;
    end else begin
      for (int i = 0; i < N * N; i++) begin
        if (w_accept && (r_fill_count == 7'(i))) begin
          r_matrix[i*W +: W] <= In_data;
        end
      end
    end
  end

  // Determinant capture on Done in WAIT; held until the next capture.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_det <= '0;
    end else if (w_capture) begin
      r_det <= Det_in;
    end else begin
      r_det <= r_det;
    end
  end

  // Handshake outputs decoded from state and forced low while Reset is high.
  always_comb begin
    In_ready   = (r_state == ST_FILL)   && !Reset;
    Start      = (r_state == ST_LAUNCH) && !Reset;
    Det_valid  = (r_state == ST_RESULT) && !Reset;
    Ack        = (r_state == ST_RESULT) && Res_ready && !Reset;
    Err        = (r_state == ST_ERROR)  && !Reset;
    q_Fill     = r_state[0];
    q_Launch   = r_state[1];
    q_Wait     = r_state[2];
    q_Result   = r_state[3];
    q_Error    = r_state[4];
    Fill_count = r_fill_count;
    Matrix     = r_matrix;
    Det_out    = r_det;
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Scoreboard bench for matrix_loader: stimulus pushes expected Start/Ack/Err
// events, a negedge monitor pops and compares them as the DUT produces them.
module tb_matrix_loader;

  localparam int N  = 8;
  localparam int W  = 32;
  localparam int NN = N * N;
  localparam int MW = NN * W;
  localparam int WL = 16;

  localparam logic [1:0] K_START = 2'd0;
  localparam logic [1:0] K_ACK   = 2'd1;
  localparam logic [1:0] K_ERR   = 2'd2;

  logic          Clk = 1'b0;
  logic          Reset, Clear, In_valid, In_last, Done, Res_ready;
  logic [W-1:0]  In_data, Det_in;
  logic          In_ready, Start, Ack, Det_valid, Err;
  logic [MW-1:0] Matrix;
  logic [W-1:0]  Det_out;
  logic [6:0]    Fill_count;
  logic          q_Fill, q_Launch, q_Wait, q_Result, q_Error;

  matrix_loader #(.N(N), .W(W), .WAIT_LIMIT(WL)) dut (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .In_valid(In_valid),
    .In_data(In_data), .In_last(In_last), .In_ready(In_ready),
    .Matrix(Matrix), .Start(Start), .Done(Done), .Det_in(Det_in),
    .Ack(Ack), .Det_out(Det_out), .Det_valid(Det_valid),
    .Res_ready(Res_ready), .Err(Err), .Fill_count(Fill_count),
    .q_Fill(q_Fill), .q_Launch(q_Launch), .q_Wait(q_Wait),
    .q_Result(q_Result), .q_Error(q_Error)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [1:0]    kind;
    logic [W-1:0]  det;
    logic [MW-1:0] mat;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference model: the matrix as a plain array plus the fill position.
  logic [W-1:0] ref_mem [NN];
  int           ref_cnt = 0;

  function automatic logic [MW-1:0] ref_packed();
    logic [MW-1:0] p;
    for (int i = 0; i < NN; i++) p[i*W +: W] = ref_mem[i];
    return p;
  endfunction

  task automatic ref_zero();
    for (int i = 0; i < NN; i++) ref_mem[i] = '0;
    ref_cnt = 0;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_mat(input string nm, input logic [MW-1:0] act, input logic [MW-1:0] exp);
    int bad;
    n_vec++;
    if (act !== exp) begin
      n_err++;
      bad = -1;
      for (int i = NN - 1; i >= 0; i--) if (act[i*W +: W] !== exp[i*W +: W]) bad = i;
      $display("FAIL %s: element %0d got %0h expected %0h", nm, bad,
               act[bad*W +: W], exp[bad*W +: W]);
    end
  endtask

  task automatic push_exp(input logic [1:0] kind, input logic [W-1:0] det);
    exp_t e;
    e.kind = kind;
    e.det  = det;
    e.mat  = ref_packed();
    exp_q.push_back(e);
  endtask

  // Monitor: every Start, Ack and rising Err must match the queue head.
  exp_t mon_e;
  logic err_d = 1'b0;
  always @(negedge Clk) begin
    if (Start) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_start: got 1 expected none");
      end else begin
        mon_e = exp_q.pop_front();
        chk("start_event_kind", Start ? 64'(K_START) : 64'd3, 64'(mon_e.kind));
        chk_mat("start_matrix", Matrix, mon_e.mat);
      end
    end
    if (Ack) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_ack: got 1 expected none");
      end else begin
        mon_e = exp_q.pop_front();
        chk("ack_event_kind", 64'(K_ACK), 64'(mon_e.kind));
        chk("ack_det_out", Det_out, mon_e.det);
        chk("ack_det_valid", Det_valid, 1);
      end
    end
    if (Err && !err_d) begin
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_err: got 1 expected none");
      end else begin
        mon_e = exp_q.pop_front();
        chk("err_event_kind", 64'(K_ERR), 64'(mon_e.kind));
      end
    end
    err_d <= Err;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One element, with an occasional idle cycle in front of it.
  task automatic send_elem(input logic [W-1:0] d, input bit last);
    if ($urandom_range(0, 3) == 0) begin
      In_valid = 1'b0;
      step();
    end
    In_valid = 1'b1;
    In_data  = d;
    In_last  = last;
    chk("in_ready_fill", In_ready, 1);
    ref_mem[ref_cnt] = d;
    if (last && ref_cnt == NN - 1) push_exp(K_START, '0);
    else if (last || ref_cnt == NN - 1) push_exp(K_ERR, '0);
    ref_cnt++;
    step();
    In_valid = 1'b0;
    In_last  = 1'b0;
  endtask

  // mode 0 random, 1 values 1..64, 2 identity
  task automatic stream(input int mode, input int count, input int last_at);
    logic [W-1:0] v;
    chk("fill_count_start", Fill_count, 64'(ref_cnt));
    for (int i = 0; i < count; i++) begin
      case (mode)
        1:       v = W'(i + 1);
        2:       v = (i / N == i % N) ? 32'd1 : 32'd0;
        default: v = $urandom;
      endcase
      send_elem(v, i == last_at);
    end
  endtask

  // Drive the core side from LAUNCH through the Ack cycle.
  task automatic finish_core(input int done_delay, input logic [W-1:0] det,
                             input int res_delay, input bit clear_in_wait);
    chk("start_pulse", Start, 1);
    chk("launch_flag", q_Launch, 1);
    chk("in_ready_launch", In_ready, 0);
    Clear = clear_in_wait;
    step();
    chk("start_single", Start, 0);
    chk("wait_flag", q_Wait, 1);
    chk_mat("matrix_hold_wait", Matrix, ref_packed());
    for (int i = 0; i < done_delay; i++) begin
      Clear = clear_in_wait && ($urandom_range(0, 1) == 1);
      step();
    end
    Clear  = clear_in_wait;
    Done   = 1'b1;
    Det_in = det;
    push_exp(K_ACK, det);
    step();
    Done   = 1'b0;
    Det_in = $urandom;
    Clear  = 1'b0;
    chk("result_flag", q_Result, 1);
    for (int i = 0; i < res_delay; i++) begin
      chk("det_valid_hold", Det_valid, 1);
      chk("ack_idle", Ack, 0);
      step();
    end
    Res_ready = 1'b1;
    #1;
    chk("ack_on_ready", Ack, 1);
    step();
    Res_ready = 1'b0;
    ref_cnt = 0;
    chk("fill_after_ack", Fill_count, 0);
    chk("det_valid_low", Det_valid, 0);
    chk("det_out_hold", Det_out, det);
    chk_mat("matrix_after_ack", Matrix, ref_packed());
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    step();
    Clear = 1'b0;
    ref_cnt = 0;
    chk("clear_to_fill", q_Fill, 1);
    chk("clear_err_low", Err, 0);
    chk("clear_fill_count", Fill_count, 0);
    chk_mat("clear_matrix_kept", Matrix, ref_packed());
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int wcnt;
    Reset = 1'b1; Clear = 1'b0; In_valid = 1'b1; In_last = 1'b0;
    In_data = 32'hDEAD_BEEF; Done = 1'b0; Det_in = '0; Res_ready = 1'b1;
    ref_zero();
    step();
    step();
    chk("rst_in_ready", In_ready, 0);
    chk("rst_ack", Ack, 0);
    chk("rst_start", Start, 0);
    chk("rst_err", Err, 0);
    chk("rst_det_valid", Det_valid, 0);
    chk("rst_fill_count", Fill_count, 0);
    chk("rst_det_out", Det_out, 0);
    chk("rst_state_fill", q_Fill, 1);
    chk_mat("rst_matrix", Matrix, ref_packed());
    Reset = 1'b0; In_valid = 1'b0; Res_ready = 1'b0;
    step();
    chk("post_rst_in_ready", In_ready, 1);

    // Sequential 1..64, determinant 0, consumer ready at once.
    stream(1, NN, NN - 1);
    finish_core($urandom_range(0, 10), 32'd0, 0, 1'b0);

    // Identity, determinant 1, consumer stalls 5 cycles.
    stream(2, NN, NN - 1);
    finish_core($urandom_range(0, 10), 32'd1, 5, 1'b0);

    // Random matrices and handshake delays.
    for (int k = 0; k < 3; k++) begin
      stream(0, NN, NN - 1);
      finish_core($urandom_range(0, 14), $urandom, $urandom_range(0, 4), 1'b0);
    end

    // Early In_last on element 10.
    stream(0, 11, 10);
    chk("early_last_err", Err, 1);
    chk("early_last_state", q_Error, 1);
    chk("early_last_in_ready", In_ready, 0);
    chk("early_last_count", Fill_count, 11);
    chk_mat("early_last_written", Matrix, ref_packed());
    In_valid = 1'b1; In_data = $urandom;
    step();
    In_valid = 1'b0;
    chk("error_ignores_valid", Fill_count, 11);
    do_clear();

    // Element 63 without In_last.
    stream(0, NN, -1);
    chk("missing_last_state", q_Error, 1);
    do_clear();

    // Watchdog: Done withheld.
    stream(0, NN, NN - 1);
    chk("wd_start", Start, 1);
    step();
    push_exp(K_ERR, '0);
    wcnt = 0;
    while (q_Wait && wcnt < 100) begin
      wcnt++;
      step();
    end
    chk("wd_wait_cycles", wcnt, WL);
    chk("wd_err", Err, 1);
    chk("wd_state", q_Error, 1);
    do_clear();

    // Done on the limit cycle wins.
    stream(0, NN, NN - 1);
    finish_core(WL - 1, $urandom, 1, 1'b0);

    // Reset mid-fill.
    stream(0, 30, -1);
    Reset = 1'b1;
    #1;
    chk("rst_mid_in_ready", In_ready, 0);
    step();
    Reset = 1'b0;
    ref_zero();
    chk("rst_mid_count", Fill_count, 0);
    chk_mat("rst_mid_matrix", Matrix, ref_packed());
    stream(0, NN, NN - 1);
    finish_core($urandom_range(0, 10), $urandom, 0, 1'b0);

    // Reset in WAIT: no Ack may follow for the aborted matrix.
    stream(0, NN, NN - 1);
    chk("rw_start", Start, 1);
    step();
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    ref_zero();
    chk("rw_state_fill", q_Fill, 1);
    chk("rw_det_out", Det_out, 0);
    Done = 1'b1; Res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rw_no_ack", Ack, 0);
      chk("rw_no_start", Start, 0);
      step();
    end
    Done = 1'b0; Res_ready = 1'b0;

    // Clear with In_valid drops the element; Clear in WAIT is ignored.
    stream(0, 5, -1);
    Clear = 1'b1; In_valid = 1'b1; In_data = $urandom;
    step();
    Clear = 1'b0; In_valid = 1'b0;
    ref_cnt = 0;
    chk("clr_valid_count", Fill_count, 0);
    chk_mat("clr_valid_matrix", Matrix, ref_packed());
    stream(0, NN, NN - 1);
    finish_core($urandom_range(2, 10), $urandom, 2, 1'b1);

    step();
    chk("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
